// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg
// Shared defaults and types for the slide-switch debouncer.
//   SW_DEBOUNCE_N_SW_DEF    number of switch channels on the board
//   SW_DEBOUNCE_SYNC_DEF    synchroniser depth
//   SW_DEBOUNCE_CYCLES_DEF  stable cycles before a level is accepted (10 ms at 100 MHz)
//   sw_vec_t                one bit per board switch
//   db_state_e              per-channel debounce phase

package sw_debounce_pkg;

    localparam int SW_DEBOUNCE_N_SW_DEF   = 4;
    localparam int SW_DEBOUNCE_SYNC_DEF   = 2;
    localparam int SW_DEBOUNCE_CYCLES_DEF = 1_000_000;

    typedef logic [3:0] sw_vec_t;

    // IDLE: synchronised input agrees with the accepted level.
    // PENDING: it disagrees and the counter is measuring how long it has done so.
    typedef enum logic {
        DB_IDLE    = 1'b0,
        DB_PENDING = 1'b1
    } db_state_e;

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_bit.sv
// debounce_bit
// One switch channel: synchroniser chain, debounce counter, accepted level and,
// when SW_DEBOUNCE_EDGE_EN is defined, registered rise/fall pulses.
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   raw     asynchronous switch pin
//   db      debounced level
//   rise    one-cycle pulse when db goes 0->1   (SW_DEBOUNCE_EDGE_EN only)
//   fall    one-cycle pulse when db goes 1->0   (SW_DEBOUNCE_EDGE_EN only)

module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = SW_DEBOUNCE_SYNC_DEF,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] syncChain_q, syncChain_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   stable_q, stable_d;
    logic                   syncLast;
    logic                   commit;
    db_state_e              state;

    // Next-state logic. The counter only ever runs while the synchronised input
    // disagrees with the accepted level; any cycle of agreement throws the whole
    // count away, so only an unbroken run of DEBOUNCE_CYCLES disagreeing cycles
    // commits. The commit clears the counter instead of letting it wrap.
    always_comb begin
        syncChain_d = {syncChain_q[SYNC_STAGES-2:0], raw};
        syncLast    = syncChain_q[SYNC_STAGES-1];
        count_d     = count_q;
        stable_d    = stable_q;
        commit      = 1'b0;
        state       = (syncLast == stable_q) ? DB_IDLE : DB_PENDING;

        case (state)
            DB_IDLE: begin
                count_d = '0;
            end
            DB_PENDING: begin
                if (count_q == CNT_LAST) begin
                    commit   = 1'b1;
                    stable_d = syncLast;
                    count_d  = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                count_d = '0;
            end
        endcase
    end

    // State registers. Reset clears the synchroniser too, so a switch held high
    // through reset is seen as a fresh 0->1 change and produces a normal rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncChain_q <= '0;
            count_q     <= '0;
            stable_q    <= 1'b0;
        end else begin
            syncChain_q <= syncChain_d;
            count_q     <= count_d;
            stable_q    <= stable_d;
        end
    end

    assign db = stable_q;

`ifdef SW_DEBOUNCE_EDGE_EN
    logic rise_q, fall_q;

    // Pulses are registered on the commit edge so they line up with the new db.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= commit &  syncLast;
            fall_q <= commit & ~syncLast;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif

endmodule : debounce_bit

// File: rtl/sw_debounce.sv
// sw_debounce
// Debounces and synchronises the board slide switches into the clk domain.
// Optional feature macro: SW_DEBOUNCE_EDGE_EN adds per-switch edge pulses.
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   sw_raw   [N_SW] asynchronous switch pins
//   sw_db    [N_SW] debounced switch levels
//   sw_rise  [N_SW] one-cycle 0->1 pulses   (SW_DEBOUNCE_EDGE_EN only)
//   sw_fall  [N_SW] one-cycle 1->0 pulses   (SW_DEBOUNCE_EDGE_EN only)

module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int N_SW            = SW_DEBOUNCE_N_SW_DEF,
    parameter int SYNC_STAGES     = SW_DEBOUNCE_SYNC_DEF,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_db
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall
`endif
);

    // Channels are fully independent; each gets its own debounce_bit.
    for (genvar g = 0; g < N_SW; g++) begin : g_chan
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .raw  (sw_raw[g]),
            .db   (sw_db[g])
`ifdef SW_DEBOUNCE_EDGE_EN
            ,
            .rise (sw_rise[g]),
            .fall (sw_fall[g])
`endif
        );
    end

endmodule : sw_debounce
